ones_count_sequencer: RTL and testbench

- Sequential controller that computes the population count of a WORD-bit input using one shared 3-input ones-counter datapath (the transistor-level one_counter cell, outputs y1:y0 = number of ones in a,b,c).
- Presents the word to the cell 3 bits per step, waits for the switch-level cell to settle, samples its 2-bit result and accumulates it.
- Sits between a requesting FSM and the single one_counter instance; one sequencer per counter instance.

---
 rtl/ones_count_sequencer_if.sv | 27 ++
 rtl/ones_count_sequencer.sv | 94 +++++++++
 tb/tb_ones_count_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ones_count_sequencer_if.sv
// Request/response and one_counter cell signals for one ones_count_sequencer.
// master = requester plus cell side of the testbench/integration; slave = the sequencer.
interface ones_count_sequencer_if #(
    parameter int WORD = 12,
    parameter int SUMW = 4
);
    logic            start;
    logic [WORD-1:0] din;
    logic            busy;
    logic            done;
    logic [SUMW-1:0] count;
    logic            oc_a;
    logic            oc_b;
    logic            oc_c;
    logic            oc_y1;
    logic            oc_y0;

    modport master (
        output start, din, oc_y1, oc_y0,
        input  busy, done, count, oc_a, oc_b, oc_c
    );

    modport slave (
        input  start, din, oc_y1, oc_y0,
        output busy, done, count, oc_a, oc_b, oc_c
    );
endinterface

// File: rtl/ones_count_sequencer.sv
// Popcount of a WORD-bit word through one shared 3-input ones-counter cell,
// three bits per step, with SETTLE hold cycles before each sample edge.
module ones_count_sequencer #(
    parameter int WORD   = 12,
    parameter int SETTLE = 1,
    parameter int SUMW   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    ones_count_sequencer_if.slave  bus
);
    localparam int NSL = WORD / 3;
    localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam int TW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [IW-1:0] LAST  = IW'(NSL - 1);
    localparam logic [TW-1:0] TINIT = TW'(SETTLE - 1);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

    state_t          r_state;
    logic [WORD-1:0] r_shreg;
    logic [IW-1:0]   r_idx;
    logic [TW-1:0]   r_timer;
    logic [SUMW-1:0] r_acc;
    logic            r_busy;
    logic            r_done;
    logic [2:0]      r_oc;

    logic [WORD-1:0] w_shnext;
    logic [SUMW-1:0] w_slice;

    assign w_shnext = r_shreg >> 3;
    assign w_slice  = SUMW'({bus.oc_y1, bus.oc_y0});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_idx   <= '0;
            r_timer <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_oc    <= 3'b000;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_shreg <= bus.din;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_timer <= TINIT;
                        r_oc    <= bus.din[2:0];
                        r_busy  <= 1'b1;
                        r_state <= S_DRIVE;
                    end else begin
                        r_busy  <= 1'b0;
                        r_oc    <= 3'b000;
                        r_state <= S_IDLE;
                    end
                end
                S_DRIVE: begin
                    if (r_timer != '0) r_timer <= r_timer - TW'(1);
                    else               r_state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    // The cell output is only ever looked at on this edge.
                    r_acc   <= r_acc + w_slice;
                    r_shreg <= w_shnext;
                    r_idx   <= r_idx + IW'(1);
                    if (r_idx == LAST) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_oc    <= 3'b000;
                        r_state <= S_DONE;
                    end else begin
                        r_timer <= TINIT;
                        r_oc    <= w_shnext[2:0];
                        r_state <= S_DRIVE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.count = r_acc;
    assign bus.oc_a  = r_oc[2];
    assign bus.oc_b  = r_oc[1];
    assign bus.oc_c  = r_oc[0];
endmodule

// File: tb/tb_ones_count_sequencer.sv
// Directed bench for ones_count_sequencer: default instance plus a SETTLE=3 instance
// for random words, each driving a behavioural one_counter cell.
module tb_ones_count_sequencer;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    ones_count_sequencer_if #(.WORD(12), .SUMW(4)) bus ();
    ones_count_sequencer_if #(.WORD(12), .SUMW(4)) bus3 ();

    ones_count_sequencer #(.WORD(12), .SETTLE(1), .SUMW(4)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    ones_count_sequencer #(.WORD(12), .SETTLE(3), .SUMW(4)) u_dut3 (
        .clk(clk), .rst(rst), .bus(bus3)
    );

    assign {bus.oc_y1, bus.oc_y0}   = {1'b0, bus.oc_a} + {1'b0, bus.oc_b} + {1'b0, bus.oc_c};
    assign {bus3.oc_y1, bus3.oc_y0} = {1'b0, bus3.oc_a} + {1'b0, bus3.oc_b} + {1'b0, bus3.oc_c};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pulse_start(input logic [11:0] w);
        bus.start = 1'b1;
        bus.din   = w;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic test_reset;
        n_chk++;
        if ({bus.busy, bus.done, bus.count, bus.oc_a, bus.oc_b, bus.oc_c} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_in: got busy=%b done=%b count=%0d oc=%b%b%b want all 0",
                     bus.busy, bus.done, bus.count, bus.oc_a, bus.oc_b, bus.oc_c);
        end
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({bus.busy, bus.done, bus.count, bus.oc_a, bus.oc_b, bus.oc_c} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_after: got busy=%b done=%b count=%0d want all 0",
                     bus.busy, bus.done, bus.count);
        end
    endtask

    task automatic test_fff;
        pulse_start(12'hFFF);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            n_chk++;
            if (bus.busy !== (n <= 8)) begin
                n_fail++;
                $display("FAIL fff_busy c%0d: got %b want %b", n, bus.busy, (n <= 8));
            end
            n_chk++;
            if (bus.done !== (n == 9)) begin
                n_fail++;
                $display("FAIL fff_done c%0d: got %b want %b", n, bus.done, (n == 9));
            end
            if (n == 9) begin
                n_chk++;
                if (bus.count !== 4'd12) begin
                    n_fail++;
                    $display("FAIL fff_count: got %0d want 12", bus.count);
                end
            end
        end
    endtask

    task automatic test_pattern;
        logic [2:0] exp_oc  [1:9] = '{3'b111, 3'b111, 3'b000, 3'b000, 3'b011, 3'b011,
                                      3'b101, 3'b101, 3'b000};
        logic [3:0] exp_cnt [1:9] = '{4'd0, 4'd0, 4'd3, 4'd3, 4'd3, 4'd3, 4'd5, 4'd5, 4'd7};
        pulse_start(12'b101_011_000_111);
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            n_chk++;
            if ({bus.oc_a, bus.oc_b, bus.oc_c} !== exp_oc[n]) begin
                n_fail++;
                $display("FAIL pat_oc c%0d: got %b%b%b want %b", n,
                         bus.oc_a, bus.oc_b, bus.oc_c, exp_oc[n]);
            end
            n_chk++;
            if (bus.count !== exp_cnt[n]) begin
                n_fail++;
                $display("FAIL pat_count c%0d: got %0d want %0d", n, bus.count, exp_cnt[n]);
            end
        end
        n_chk++;
        if (bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL pat_done: got %b want 1", bus.done);
        end
    endtask

    task automatic test_back_to_back;
        bus.din   = 12'h000;
        bus.start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 28; n++) begin
            @(negedge clk);
            n_chk++;
            if (bus.done !== (n == 9 || n == 18 || n == 27)) begin
                n_fail++;
                $display("FAIL b2b_done c%0d: got %b want %b", n, bus.done,
                         (n == 9 || n == 18 || n == 27));
            end
            n_chk++;
            if (bus.busy !== (n < 27 && (n % 9) != 0)) begin
                n_fail++;
                $display("FAIL b2b_busy c%0d: got %b want %b", n, bus.busy,
                         (n < 27 && (n % 9) != 0));
            end
            n_chk++;
            if (bus.count !== 4'd0) begin
                n_fail++;
                $display("FAIL b2b_count c%0d: got %0d want 0", n, bus.count);
            end
            if (n == 20) bus.start = 1'b0;
        end
    endtask

    task automatic test_ignore_start;
        int dones = 0;
        pulse_start(12'h001);
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
            if (n == 9) begin
                n_chk++;
                if (bus.done !== 1'b1 || bus.count !== 4'd1) begin
                    n_fail++;
                    $display("FAIL ign_done9: got done=%b count=%0d want done=1 count=1",
                             bus.done, bus.count);
                end
            end
            if (n == 3) begin
                bus.start = 1'b1;
                bus.din   = 12'hFFF;
            end
            if (n == 6) bus.start = 1'b0;
        end
        n_chk++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL ign_dones: got %0d want 1", dones);
        end
        n_chk++;
        if (bus.count !== 4'd1) begin
            n_fail++;
            $display("FAIL ign_count_hold: got %0d want 1", bus.count);
        end
    endtask

    task automatic test_reset_mid;
        pulse_start(12'hFFF);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        n_chk++;
        if ({bus.busy, bus.done, bus.count, bus.oc_a, bus.oc_b, bus.oc_c} !== 9'd0) begin
            n_fail++;
            $display("FAIL rstmid: got busy=%b done=%b count=%0d oc=%b%b%b want all 0",
                     bus.busy, bus.done, bus.count, bus.oc_a, bus.oc_b, bus.oc_c);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            n_chk++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_quiet c%0d: got done=%b busy=%b want 0 0",
                         n, bus.done, bus.busy);
            end
        end
        pulse_start(12'h5A5);
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            n_chk++;
            if (bus.done !== (n == 9)) begin
                n_fail++;
                $display("FAIL rstmid_rerun_done c%0d: got %b want %b", n, bus.done, (n == 9));
            end
        end
        n_chk++;
        if (bus.count !== 4'd6) begin
            n_fail++;
            $display("FAIL rstmid_rerun_count: got %0d want 6", bus.count);
        end
    endtask

    task automatic test_random_settle3;
        logic [11:0] w;
        int          got;
        for (int i = 0; i < 200; i++) begin
            w          = 12'($urandom);
            bus3.din   = w;
            bus3.start = 1'b1;
            @(posedge clk);
            #1 bus3.start = 1'b0;
            got = 0;
            for (int c = 1; c <= 30; c++) begin
                @(negedge clk);
                if (bus3.done === 1'b1) begin
                    got = c;
                    break;
                end
            end
            n_chk++;
            if (got != 17) begin
                n_fail++;
                $display("FAIL rnd_latency w=%h: got %0d want 17", w, got);
            end
            n_chk++;
            if ($isunknown(bus3.count) || bus3.count !== 4'($countones(w))) begin
                n_fail++;
                $display("FAIL rnd_count w=%h: got %0d want %0d", w, bus3.count, $countones(w));
            end
        end
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rst        = 1'b0;
        bus.start  = 1'b0;
        bus.din    = '0;
        bus3.start = 1'b0;
        bus3.din   = '0;
        repeat (2) @(negedge clk);
        test_reset;
        test_fff;
        @(negedge clk);
        test_pattern;
        @(negedge clk);
        test_back_to_back;
        test_ignore_start;
        test_reset_mid;
        @(negedge clk);
        test_random_settle3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
